sr_cmd_sequencer: RTL and testbench
===================================

Name: sr_cmd_sequencer

Overview:
- Upstream driver for the team's SR flip-flop stage. Queues set/clear/toggle/no-op commands over a valid/ready interface.
- Converts each command into a timed S/R drive pulse. Never drives S=R=1, which would put the flip-flop in its forbidden state.
- Keeps a shadow of the expected Q. Checks the flip-flop's Q fed back on Q_FB and flags mismatches.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, ≥2)
- CNT_W, 4, width of per-command hold length

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  asynchronous, active-high reset
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  FIFO can accept; equals !full && !RST
- CMD_OP  in  2  00 NOP, 01 CLR, 10 SET, 11 TOGGLE
- CMD_LEN  in  CNT_W  drive cycles minus 1
- Q_FB  in  1  Q output of downstream SR flip-flop
- S  out  1  set drive to flip-flop (registered)
- R  out  1  reset drive to flip-flop (registered)
- Q_EXP  out  1  expected flip-flop state (registered)
- BUSY  out  1  FIFO non-empty or FSM not IDLE
- ERR  out  1  sticky feedback-mismatch flag

Behaviour:
- Reset (async, RST=1): S=R=0, Q_EXP=0, ERR=0, FIFO empty, FSM=IDLE, counter=0, BUSY=0, CMD_READY=0.
- Accept: a push occurs on the posedge where CMD_VALID && CMD_READY. {OP,LEN} is stored in order. When full, CMD_READY=0 and the FIFO does not change.
- Same-edge push and pop are both honoured, and the count is unchanged.
- FSM states:
  - IDLE:
    - If the FIFO is non-empty, pop the head at this edge and load it (see Load).
    - Go to DRIVE.
  - DRIVE:
    - If counter==0: S=R=0 at this edge, go to GAP.
    - Otherwise counter-=1, S/R held.
  - GAP: exactly one cycle with S=R=0, then:
    - if the FIFO is non-empty, pop and load, go to DRIVE;
    - otherwise go to IDLE.
- Load (registered at the pop edge):
  - counter=LEN.
  - TOGGLE resolves with the current Q_EXP: 0 gives SET, 1 gives CLR.
  - SET gives S=1, R=0, Q_EXP=1.
  - CLR gives S=0, R=1, Q_EXP=0.
  - NOP gives S=R=0 and leaves Q_EXP unchanged.
  - The resolved op is stored in chk_op for the check.
- Timing:
  - Push at edge t into an empty FIFO while IDLE: S/R valid after edge t+1. There is no bypass.
  - S or R stays high for exactly LEN+1 cycles, followed by one GAP cycle.
  - Back-to-back commands are therefore spaced LEN+2 cycles apart.
- Invariant: S&R==0 in every cycle, including reset exit and TOGGLE resolution.
- Check:
  - Applies only during GAP when chk_op≠NOP. By then Q_FB has settled, because the flip-flop captured S/R for at least one edge.
  - If Q_FB != Q_EXP, ERR=1 at the GAP-exit edge.
  - ERR is cleared only by RST.
- BUSY = (state≠IDLE) || (count≠0). It falls on the edge leaving GAP to IDLE.
- Counter width is CNT_W. LEN=all-ones gives 2^CNT_W drive cycles, with no wrap issue.
- RST asserted mid-DRIVE: outputs go to zero immediately, and queued commands are discarded.

Decomposition:
- Shared package sr_pkg:
  - op encodings (OP_NOP, OP_CLR, OP_SET, OP_TOG);
  - FSM state enum (IDLE, DRIVE, GAP);
  - default DEPTH/CNT_W.
- Sub-module sr_cmd_fifo:
  - parametric synchronous FIFO with async active-high reset on CLK/RST;
  - ports push/pop/din/dout/full/empty/count.
- sr_cmd_sequencer holds the FSM, counter, Q_EXP and the checker.

Test Plan:
- Reset mid-operation: SET LEN=5, assert RST 2 cycles into DRIVE -> S, R, Q_EXP, BUSY and ERR are 0 with no clock edge needed; after release CMD_READY=1 and FIFO empty.
- Single SET LEN=2 pushed at edge 0, Q_FB follows the flip-flop model -> S=1 after edges 1-3 (3 cycles), R=0 throughout, GAP cycle 4, Q_EXP=1, BUSY=0 after edge 5, ERR=0.
- Backpressure: 6 SET/CLR commands LEN=3 offered back-to-back, DEPTH=4 -> CMD_READY drops to 0 while full; all 6 are issued in order, each 5 cycles apart, with none lost or duplicated.
- TOGGLE x3 from reset (Q_EXP=0) -> resolved SET, CLR, SET; Q_EXP sequence 1,0,1; S&R never 1 in any cycle.
- Mismatch: SET LEN=0 with Q_FB tied to 0 -> ERR=1 after GAP exit edge and still 1 after further good commands, until RST.
- NOP LEN=0 after a SET -> S=R=0 for 1 drive cycle plus GAP, Q_EXP stays 1, no check performed (ERR unchanged even with Q_FB=0).

Source files
------------

// File: rtl/sr_pkg.sv
// Shared op encodings, FSM states and default sizing for the SR command sequencer.
package sr_pkg;

    localparam int unsigned DEF_DEPTH = 4;
    localparam int unsigned DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        OP_NOP = 2'b00,
        OP_CLR = 2'b01,
        OP_SET = 2'b10,
        OP_TOG = 2'b11
    } sr_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        DRIVE = 2'b01,
        GAP   = 2'b10
    } sr_state_e;

    // TOGGLE becomes a concrete SET/CLR against the current expected Q.
    function automatic sr_op_e resolve_op(input sr_op_e op, input logic q_exp);
        if (op == OP_TOG) begin
            return q_exp ? OP_CLR : OP_SET;
        end
        return op;
    endfunction

endpackage

// File: rtl/sr_cmd_fifo.sv
// Power-of-two synchronous FIFO holding queued {op, len} commands.
module sr_cmd_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 6
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [WIDTH-1:0]           i_din,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] LP_FULL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [AW:0]      w_count_d;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == LP_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_comb begin
        w_count_d = r_count;
        unique case ({w_do_push, w_do_pop})
            2'b10:   w_count_d = r_count + (AW + 1)'(1);
            2'b01:   w_count_d = r_count - (AW + 1)'(1);
            default: w_count_d = r_count;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge CLK) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/sr_cmd_sequencer.sv
// Turns queued set/clear/toggle/no-op commands into timed, never-overlapping S/R
// pulses and checks the flip-flop's Q feedback against a shadow copy.
module sr_cmd_sequencer
    import sr_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CMD_VALID,
    output logic             CMD_READY,
    input  logic [1:0]       CMD_OP,
    input  logic [CNT_W-1:0] CMD_LEN,
    input  logic             Q_FB,
    output logic             S,
    output logic             R,
    output logic             Q_EXP,
    output logic             BUSY,
    output logic             ERR
);

    localparam int unsigned W  = CNT_W + 2;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_load;
    logic [CW-1:0]   w_count;
    logic [W-1:0]    w_head;
    sr_op_e          w_res_op;

    sr_state_e       r_state,  w_state_d;
    logic [CNT_W-1:0] r_cnt,   w_cnt_d;
    logic            r_s,      w_s_d;
    logic            r_r,      w_r_d;
    logic            r_q_exp,  w_q_exp_d;
    logic            r_err,    w_err_d;
    sr_op_e          r_chk_op, w_chk_op_d;

    assign CMD_READY = !w_full && !RST;
    assign w_push    = CMD_VALID && CMD_READY;

    sr_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   ({CMD_OP, CMD_LEN}),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_res_op = resolve_op(sr_op_e'(w_head[W-1:CNT_W]), r_q_exp);

    always_comb begin
        w_state_d  = r_state;
        w_cnt_d    = r_cnt;
        w_s_d      = r_s;
        w_r_d      = r_r;
        w_q_exp_d  = r_q_exp;
        w_err_d    = r_err;
        w_chk_op_d = r_chk_op;
        w_pop      = 1'b0;
        w_load     = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (!w_empty) w_load = 1'b1;
            end
            DRIVE: begin
                if (r_cnt == '0) begin
                    w_s_d     = 1'b0;
                    w_r_d     = 1'b0;
                    w_state_d = GAP;
                end else begin
                    w_cnt_d = r_cnt - CNT_W'(1);
                end
            end
            GAP: begin
                // Q_FB has had at least one edge to follow S/R by now.
                if (r_chk_op != OP_NOP && Q_FB != r_q_exp) w_err_d = 1'b1;
                if (!w_empty) w_load = 1'b1;
                else          w_state_d = IDLE;
            end
            default: w_state_d = IDLE;
        endcase

        if (w_load) begin
            w_pop      = 1'b1;
            w_state_d  = DRIVE;
            w_cnt_d    = w_head[CNT_W-1:0];
            w_chk_op_d = w_res_op;
            w_s_d      = 1'b0;
            w_r_d      = 1'b0;
            if (w_res_op == OP_SET) begin
                w_s_d     = 1'b1;
                w_q_exp_d = 1'b1;
            end else if (w_res_op == OP_CLR) begin
                w_r_d     = 1'b1;
                w_q_exp_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_s      <= 1'b0;
            r_r      <= 1'b0;
            r_q_exp  <= 1'b0;
            r_err    <= 1'b0;
            r_chk_op <= OP_NOP;
        end else begin
            r_state  <= w_state_d;
            r_cnt    <= w_cnt_d;
            r_s      <= w_s_d;
            r_r      <= w_r_d;
            r_q_exp  <= w_q_exp_d;
            r_err    <= w_err_d;
            r_chk_op <= w_chk_op_d;
        end
    end

    assign S     = r_s;
    assign R     = r_r;
    assign Q_EXP = r_q_exp;
    assign ERR   = r_err;
    assign BUSY  = (r_state != IDLE) || (w_count != '0);

endmodule

// File: tb/tb_sr_cmd_sequencer.sv
// Directed bench for sr_cmd_sequencer: timeline-based reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_sr_cmd_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam logic [1:0] NOP = 2'b00;
    localparam logic [1:0] CLR = 2'b01;
    localparam logic [1:0] SET = 2'b10;
    localparam logic [1:0] TOG = 2'b11;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             CMD_VALID = 1'b0;
    logic             CMD_READY;
    logic [1:0]       CMD_OP = 2'b00;
    logic [CNT_W-1:0] CMD_LEN = '0;
    logic             Q_FB;
    logic             S, R, Q_EXP, BUSY, ERR;

    logic fb_force = 1'b0;
    logic fb_val   = 1'b0;
    logic q_ff;

    int n_pass  = 0;
    int n_total = 0;
    int stalls  = 0;

    sr_cmd_sequencer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .CMD_VALID (CMD_VALID),
        .CMD_READY (CMD_READY),
        .CMD_OP    (CMD_OP),
        .CMD_LEN   (CMD_LEN),
        .Q_FB      (Q_FB),
        .S         (S),
        .R         (R),
        .Q_EXP     (Q_EXP),
        .BUSY      (BUSY),
        .ERR       (ERR)
    );

    always #5 CLK = ~CLK;

    // Downstream SR flip-flop; the force lets a test break the feedback path.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)    q_ff <= 1'b0;
        else if (S) q_ff <= 1'b1;
        else if (R) q_ff <= 1'b0;
    end
    assign Q_FB = fb_force ? fb_val : q_ff;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: a queue of accepted commands and a timeline of edges.
    typedef struct packed {logic [1:0] op; logic [CNT_W-1:0] len;} cmd_t;
    typedef struct {logic [1:0] sr; int e; logic q;} pulse_t;

    cmd_t       mq[$];
    pulse_t     plog[$];
    int         m_edge, m_start, m_len, m_next;
    bit         m_active;
    logic [1:0] m_op;
    logic       m_q, m_err;
    logic [1:0] prev_sr;

    task automatic m_reset();
        mq.delete();
        m_edge = 0; m_start = 0; m_len = 0; m_next = 0;
        m_active = 1'b0; m_op = NOP; m_q = 1'b0; m_err = 1'b0; prev_sr = 2'b00;
    endtask

    task automatic m_step();
        bit   push_ok;
        cmd_t c;
        m_edge++;
        push_ok = CMD_VALID && (mq.size() < DEPTH);
        if (m_active && m_edge == m_next && m_op != NOP && Q_FB != m_q) m_err = 1'b1;
        if (mq.size() != 0 && m_edge >= m_next) begin
            c = mq.pop_front();
            m_op = (c.op == TOG) ? (m_q ? CLR : SET) : c.op;
            if (m_op == SET)      m_q = 1'b1;
            else if (m_op == CLR) m_q = 1'b0;
            m_start  = m_edge;
            m_len    = int'(c.len);
            m_next   = m_edge + m_len + 2;
            m_active = 1'b1;
        end
        if (push_ok) begin
            c = '{op: CMD_OP, len: CMD_LEN};
            mq.push_back(c);
        end
    endtask

    task automatic m_compare();
        bit     drv;
        pulse_t p;
        drv = m_active && (m_edge >= m_start) && (m_edge <= m_start + m_len);
        chk("S", 32'(S), 32'(drv && m_op == SET));
        chk("R", 32'(R), 32'(drv && m_op == CLR));
        chk("S_and_R", 32'(S & R), 0);
        chk("Q_EXP", 32'(Q_EXP), 32'(m_q));
        chk("ERR", 32'(ERR), 32'(m_err));
        chk("BUSY", 32'(BUSY), 32'(mq.size() != 0 || (m_active && m_edge < m_next)));
        chk("CMD_READY", 32'(CMD_READY), 32'(mq.size() < DEPTH));
        if ({S, R} != prev_sr && {S, R} != 2'b00) begin
            p.sr = {S, R}; p.e = m_edge; p.q = Q_EXP;
            plog.push_back(p);
        end
        prev_sr = {S, R};
    endtask

    initial m_reset();

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_reset();
        end else begin
            m_step();
            #1;
            if (!RST) m_compare();
        end
    end

    // Called at a negedge; returns at the negedge after acceptance with CMD_VALID still high.
    task automatic push_cmd(input logic [1:0] op, input logic [CNT_W-1:0] len);
        int  waited = 0;
        bit  done   = 1'b0;
        CMD_VALID = 1'b1; CMD_OP = op; CMD_LEN = len;
        while (!done) begin
            @(posedge CLK);
            if (CMD_READY) begin
                done = 1'b1;
            end else begin
                stalls++;
                waited++;
                if (waited > 100) begin
                    chk("push_timeout", 1, 0);
                    done = 1'b1;
                end
            end
        end
        @(negedge CLK);
    endtask

    task automatic wait_idle(input string name);
        int  n    = 0;
        bit  done = 1'b0;
        while (!done) begin
            if (!BUSY) begin
                done = 1'b1;
            end else if (n > 300) begin
                chk({name, "_idle_timeout"}, 1, 0);
                done = 1'b1;
            end else begin
                @(negedge CLK);
                n++;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; CMD_VALID = 1'b0; fb_force = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        plog.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

    initial begin
        logic [31:0] s_bits, r_bits, b_bits;

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_outputs", 32'({S, R, Q_EXP, BUSY, ERR}), 0);
        chk("rst_ready", 32'(CMD_READY), 0);
        RST = 1'b0;
        @(negedge CLK);
        chk("rst_exit_ready", 32'(CMD_READY), 1);

        // Single SET LEN=2 pushed at edge 0
        plog.delete();
        push_cmd(SET, 4'd2);
        CMD_VALID = 1'b0;
        s_bits = '0; r_bits = '0; b_bits = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            s_bits[k] = S; r_bits[k] = R; b_bits[k] = BUSY;
        end
        chk("set_S_pulse", s_bits, 32'h07);
        chk("set_R_low", r_bits, 32'h00);
        chk("set_BUSY", b_bits, 32'h0F);
        chk("set_QEXP", 32'(Q_EXP), 1);
        chk("set_ERR", 32'(ERR), 0);

        // Reset mid-DRIVE with a second command queued
        do_reset();
        push_cmd(SET, 4'd5);
        push_cmd(CLR, 4'd1);
        CMD_VALID = 1'b0;
        @(negedge CLK);
        chk("midrst_pre_S", 32'(S), 1);
        #2 RST = 1'b1;
        #1 chk("midrst_outputs", 32'({S, R, Q_EXP, BUSY, ERR}), 0);
        @(negedge CLK);
        RST = 1'b0;
        plog.delete();
        #1 chk("midrst_ready", 32'(CMD_READY), 1);
        chk("midrst_empty", 32'(BUSY), 0);
        repeat (10) @(negedge CLK);
        chk("midrst_discarded", plog.size(), 0);

        // Backpressure: six alternating commands, LEN=3
        do_reset();
        stalls = 0;
        for (int i = 0; i < 6; i++) push_cmd((i % 2 == 1) ? CLR : SET, 4'd3);
        CMD_VALID = 1'b0;
        wait_idle("bp");
        chk("bp_stalled", 32'(stalls > 0), 1);
        chk("bp_count", plog.size(), 6);
        if (plog.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("bp_order", 32'(plog[i].sr), (i % 2 == 1) ? 32'h1 : 32'h2);
                chk("bp_spacing", plog[i].e - plog[0].e, 5 * i);
            end
        end

        // TOGGLE x3 from Q_EXP=0
        do_reset();
        for (int i = 0; i < 3; i++) push_cmd(TOG, 4'd1);
        CMD_VALID = 1'b0;
        wait_idle("tog");
        chk("tog_count", plog.size(), 3);
        if (plog.size() == 3) begin
            chk("tog_ops", 32'({plog[0].sr, plog[1].sr, plog[2].sr}), 32'h26);
            chk("tog_qexp", 32'({plog[0].q, plog[1].q, plog[2].q}), 32'h5);
        end

        // Feedback mismatch is sticky until reset
        do_reset();
        fb_force = 1'b1; fb_val = 1'b0;
        push_cmd(SET, 4'd0);
        CMD_VALID = 1'b0;
        wait_idle("mm1");
        chk("mm_err_set", 32'(ERR), 1);
        fb_force = 1'b0;
        push_cmd(CLR, 4'd0);
        push_cmd(SET, 4'd1);
        CMD_VALID = 1'b0;
        wait_idle("mm2");
        chk("mm_err_sticky", 32'(ERR), 1);
        chk("mm_qexp", 32'(Q_EXP), 1);
        @(negedge CLK);
        RST = 1'b1;
        #1 chk("mm_err_cleared", 32'(ERR), 0);
        @(negedge CLK);
        RST = 1'b0;

        // NOP after SET: no drive, no check
        do_reset();
        push_cmd(SET, 4'd0);
        CMD_VALID = 1'b0;
        wait_idle("nop1");
        fb_force = 1'b1; fb_val = 1'b0;
        push_cmd(NOP, 4'd0);
        CMD_VALID = 1'b0;
        s_bits = '0; b_bits = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            s_bits[k] = S | R; b_bits[k] = BUSY;
        end
        chk("nop_no_drive", s_bits, 32'h0);
        chk("nop_BUSY", b_bits, 32'h3);
        chk("nop_err", 32'(ERR), 0);
        chk("nop_qexp", 32'(Q_EXP), 1);
        fb_force = 1'b0;

        repeat (2) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
